// File: rtl/qmult_arbiter.sv
// Round-robin front end sharing one sign-magnitude fixed-point multiplier among four requesters.
// Operands and result are registered; each result comes back tagged with its requester id.

module qmult #(
  parameter int Q = 19,
  parameter int N = 32
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         o_ovr
);
  logic [2*N-3:0] w_prod;
  logic [2*N-3:0] w_shift;

  // Magnitude product, rescaled by Q; anything left above the N-1 magnitude bits is overflow.
  assign w_prod   = {{(N-1){1'b0}}, i_multiplicand[N-2:0]} * {{(N-1){1'b0}}, i_multiplier[N-2:0]};
  assign w_shift  = w_prod >> Q;
  assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], w_shift[N-2:0]};
  assign o_ovr    = |w_shift[2*N-3:N-1];
endmodule

module qmult_arbiter #(
  parameter int Q    = 19,
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  output logic [1:0]        o_rsp_id,
  output logic [N-1:0]      o_rsp_result,
  output logic              o_rsp_ovr,
  input  logic              i_rsp_ready,
  input  logic              i_ovr_clr,
  output logic [7:0]        o_ovr_cnt
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t       r_state;
  logic [1:0]   r_ptr;
  logic [1:0]   r_id;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_rsp_valid;
  logic [1:0]   r_rsp_id;
  logic [N-1:0] r_rsp_result;
  logic         r_rsp_ovr;
  logic [7:0]   r_ovr_cnt;

  logic         w_any;
  logic [1:0]   w_win;
  logic [N-1:0] w_result;
  logic         w_ovr;

  // First valid requester at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!w_any && i_req_valid[r_ptr + 2'(i)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 2'(i);
      end
    end
  end

  assign o_req_ready = (r_state == IDLE && w_any) ? (NREQ'(1) << w_win) : '0;

  qmult #(.Q(Q), .N(N)) u_qmult (
    .i_multiplicand (r_a),
    .i_multiplier   (r_b),
    .o_result       (w_result),
    .o_ovr          (w_ovr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= 2'd0;
      r_id         <= 2'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 2'd0;
      r_rsp_result <= '0;
      r_rsp_ovr    <= 1'b0;
      r_ovr_cnt    <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= i_req_a[w_win*N +: N];
            r_b     <= i_req_b[w_win*N +: N];
            r_id    <= w_win;
            r_ptr   <= w_win + 2'd1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_rsp_result <= w_result;
          r_rsp_ovr    <= w_ovr;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Clear takes priority over a same-cycle overflow increment.
      if (i_ovr_clr)
        r_ovr_cnt <= 8'd0;
      else if (r_state == MUL && w_ovr && r_ovr_cnt != 8'hFF)
        r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_ovr    = r_rsp_ovr;
  assign o_ovr_cnt    = r_ovr_cnt;
endmodule

// File: tb/tb_qmult_arbiter.sv
// Directed and randomized bench for qmult_arbiter against an arithmetic reference model.

module tb_qmult_arbiter;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic [3:0]   i_req_valid = '0;
  logic [127:0] i_req_a = '0;
  logic [127:0] i_req_b = '0;
  logic [3:0]   o_req_ready;
  logic         o_rsp_valid;
  logic [1:0]   o_rsp_id;
  logic [31:0]  o_rsp_result;
  logic         o_rsp_ovr;
  logic         i_rsp_ready = 1'b0;
  logic         i_ovr_clr = 1'b0;
  logic [7:0]   o_ovr_cnt;

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  qmult_arbiter #(.Q(19), .N(32), .NREQ(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_req_ready  (o_req_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .o_rsp_ovr    (o_rsp_ovr),
    .i_rsp_ready  (i_rsp_ready),
    .i_ovr_clr    (i_ovr_clr),
    .o_ovr_cnt    (o_ovr_cnt)
  );

  always #5 i_clk = ~i_clk;

  // {ovr, result}: magnitudes multiplied as integers, divided by 2^19, sign = xor of signs.
  function automatic logic [32:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, m, q;
    ma = longint'(a & 32'h7FFF_FFFF);
    mb = longint'(b & 32'h7FFF_FFFF);
    m  = ma * mb;
    q  = m / (64'd1 << 19);
    ref_q = {q >= (64'd1 << 31), a[31] ^ b[31], q[30:0]};
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] x0, input logic [31:0] x1,
                                         input logic [31:0] x2, input logic [31:0] x3);
    pack4 = {x3, x2, x1, x0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One full request/response round trip; dly = cycles i_rsp_ready is held low in RESP.
  task automatic txn(input logic [3:0] v, input logic [127:0] av, input logic [127:0] bv,
                     input int dly, input bit hold, input bit clr);
    int win;
    logic [32:0] e;
    i_req_valid = v;
    i_req_a     = av;
    i_req_b     = bv;
    #1;
    win = -1;
    for (int i = 0; i < 4; i++)
      if (win < 0 && v[(m_ptr + i) % 4]) win = (m_ptr + i) % 4;
    if (win < 0) begin
      chk("idle_ready", 64'(o_req_ready), 64'd0);
      step();
      chk("idle_no_rsp", 64'(o_rsp_valid), 64'd0);
      return;
    end
    chk("grant", 64'(o_req_ready), 64'(4'b0001 << win));
    e = ref_q(av[win*32 +: 32], bv[win*32 +: 32]);
    m_ptr = (win + 1) % 4;
    step();
    chk("mul_ready", 64'(o_req_ready), 64'd0);
    chk("mul_valid", 64'(o_rsp_valid), 64'd0);
    if (!hold) i_req_valid = '0;
    i_rsp_ready = (dly == 0);
    i_ovr_clr   = clr;
    step();
    i_ovr_clr = 1'b0;
    if (clr) m_cnt = 0;
    else if (e[32] && m_cnt < 255) m_cnt++;
    for (int d = 0; d <= dly; d++) begin
      chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
      chk("rsp_id", 64'(o_rsp_id), 64'(win));
      chk("rsp_result", 64'(o_rsp_result), 64'(e[31:0]));
      chk("rsp_ovr", 64'(o_rsp_ovr), 64'(e[32]));
      chk("ovr_cnt", 64'(o_ovr_cnt), 64'(m_cnt));
      chk("resp_ready", 64'(o_req_ready), 64'd0);
      if (d == dly) i_rsp_ready = 1'b1;
      step();
    end
    chk("rsp_drop", 64'(o_rsp_valid), 64'd0);
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra [4];
    logic [31:0] rb [4];

    #2 i_rst_n = 1'b0;
    #10;
    chk("rst_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_id", 64'(o_rsp_id), 64'd0);
    chk("rst_result", 64'(o_rsp_result), 64'd0);
    chk("rst_ovr", 64'(o_rsp_ovr), 64'd0);
    chk("rst_cnt", 64'(o_ovr_cnt), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd0);
    step();
    i_rst_n = 1'b1;
    step();

    txn(4'b0001, pack4(32'h001921FB, 0, 0, 0), pack4(32'h00100000, 0, 0, 0), 0, 0, 0);
    chk("pi_x2", 64'(ref_q(32'h001921FB, 32'h00100000)), 64'h0_003243F6);
    txn(4'b0100, pack4(0, 0, 32'h801921FB, 0), pack4(0, 0, 32'h00080000, 0), 0, 0, 0);
    txn(4'b1000, pack4(0, 0, 0, 32'h00001234), pack4(0, 0, 0, 32'h00080000), 0, 0, 0);

    for (int k = 0; k < 5; k++)
      txn(4'b1111, pack4(32'h00080000, 32'h00100000, 32'h00180000, 32'h80200000),
          pack4(32'h00040000, 32'h00040000, 32'h00040000, 32'h00040000), 0, 1, 0);

    txn(4'b1111, pack4(1, 32'h00123456, 3, 4), pack4(5, 32'h80080000, 7, 8), 5, 1, 0);

    for (int k = 0; k < 257; k++)
      txn(4'b0001, pack4(32'h40000000, 0, 0, 0), pack4(32'h40000000, 0, 0, 0), 0, 0, 0);
    chk("cnt_sat", 64'(o_ovr_cnt), 64'd255);
    txn(4'b0001, pack4(32'h40000000, 0, 0, 0), pack4(32'h40000000, 0, 0, 0), 0, 0, 1);
    chk("cnt_clr", 64'(o_ovr_cnt), 64'd0);

    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 4; j++) begin
        ra[j] = $urandom;
        rb[j] = $urandom;
        if ($urandom_range(0, 2) != 0) begin
          ra[j] = ra[j] & 32'h800FFFFF;
          rb[j] = rb[j] & 32'h801FFFFF;
        end
      end
      txn(4'($urandom_range(0, 15)), pack4(ra[0], ra[1], ra[2], ra[3]),
          pack4(rb[0], rb[1], rb[2], rb[3]), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    // Leave the pointer at 1 and the counter non-zero, then reset in MUL.
    txn(4'b0001, pack4(32'h40000000, 0, 0, 0), pack4(32'h40000000, 0, 0, 0), 0, 0, 0);
    i_req_valid = 4'b1111;
    i_req_a     = pack4(1, 32'h00080000, 3, 4);
    i_req_b     = pack4(1, 32'h00080000, 3, 4);
    #1;
    chk("pre_rst_grant", 64'(o_req_ready), 64'(4'b0010));
    step();
    i_req_valid = '0;
    i_rst_n = 1'b0;
    #1;
    m_ptr = 0;
    m_cnt = 0;
    chk("midrst_valid", 64'(o_rsp_valid), 64'd0);
    chk("midrst_id", 64'(o_rsp_id), 64'd0);
    chk("midrst_result", 64'(o_rsp_result), 64'd0);
    chk("midrst_ovr", 64'(o_rsp_ovr), 64'd0);
    chk("midrst_cnt", 64'(o_ovr_cnt), 64'd0);
    chk("midrst_ready", 64'(o_req_ready), 64'd0);
    step();
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_no_rsp", 64'(o_rsp_valid), 64'd0);
    end
    txn(4'b1110, pack4(0, 32'h00100000, 32'h00200000, 0), pack4(0, 32'h00080000, 32'h00080000, 0), 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/qmult_arbiter.md
Name: qmult_arbiter

Overview:
Shares one qmult instance (sign-magnitude fixed point, bit N-1 = sign, Q fractional bits) between NREQ requesters. Uses a round-robin arbiter and valid/ready handshakes on both sides. Registers the operands and the result, and returns each result tagged with the requester index. Also keeps a saturating overflow event counter for the FP datapath status register.

Parameters:
Q, 19, fractional bits, passed to qmult
N, 32, word width including sign bit, passed to qmult
NREQ, 4, number of requesters (fixed at 4 in this revision; ID width 2)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NREQ  per-requester request valid
i_req_a  in  NREQ*N  multiplicands, requester k at [k*N +: N]
i_req_b  in  NREQ*N  multipliers, requester k at [k*N +: N]
o_req_ready  out  NREQ  one-hot grant/accept
o_rsp_valid  out  1  result valid
o_rsp_id  out  2  index of the requester that owns the result
o_rsp_result  out  N  qmult product
o_rsp_ovr  out  1  qmult overflow flag for this product
i_rsp_ready  in  1  consumer accepts the result
i_ovr_clr  in  1  synchronous clear of the overflow counter
o_ovr_cnt  out  8  saturating count of products with ovr=1

Behaviour:
- Reset is asynchronous on i_rst_n low:
  - state = IDLE, round-robin pointer = 0.
  - o_rsp_valid = 0, o_rsp_id = 0, o_rsp_result = 0, o_rsp_ovr = 0, o_ovr_cnt = 0.
  - Operand registers are cleared to 0.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - o_req_ready is combinational. It is one-hot for the first asserted i_req_valid at or after the pointer, scanning upward with wrap 3->0. It is 0 if no request is valid.
  - On accept (valid & ready): register the operands and the ID, set pointer = winner+1 mod 4, go to MUL.
- MUL:
  - The registered operands drive qmult.
  - Register the qmult output into o_rsp_result/o_rsp_ovr, set o_rsp_valid = 1, go to RESP.
- RESP:
  - Hold o_rsp_* stable while i_rsp_ready = 0.
  - On the cycle o_rsp_valid & i_rsp_ready: clear o_rsp_valid and return to IDLE.
  - The next grant is issued the following cycle, with no bypass.
- o_req_ready is 0 in MUL and RESP.
- Latency and throughput:
  - Accept at cycle t gives o_rsp_valid high at t+2.
  - Maximum throughput is one product per 3 cycles (i_rsp_ready held high).
- Requester contract: hold i_req_valid and operands stable until accepted. Dropping valid before accept is allowed and simply yields no grant.
- Arithmetic:
  - The result is exactly qmult #(Q,N) of the registered a and b. Sign, truncation and overflow semantics belong to qmult; this block does not alter them.
  - With Q=19 the integer range is 12 bits, so the largest magnitude is just under 4096.0.
- Overflow counter:
  - Increments by 1 on the MUL->RESP transition when ovr=1.
  - Saturates at 255.
  - i_ovr_clr clears it to 0; clear wins over a same-cycle increment.
- Fairness: a requester that holds valid is granted within 4 grants.
- Reset mid-operation: any captured request or pending response is discarded, and no response is produced for it.

Test Plan:
- Requester 0 sends a=0x001921FB (pi), b=0x00100000 (2.0), others idle → o_req_ready=0001 at t; at t+2 o_rsp_valid=1, id=0, result=0x003243F6, ovr=0.
- Requester 2 sends a=0x801921FB (-pi), b=0x00080000 (1.0) → result=0x801921FB, id=2, ovr=0.
- All four valid continuously, pointer=0, i_rsp_ready=1 → grants in order 0,1,2,3,0 with one accept every 3 cycles; ids match the grant order.
- i_rsp_ready held 0 for 5 cycles in RESP → o_rsp_* stable, o_req_ready=0000 throughout; accept on cycle 6; next grant the following cycle.
- a=b=0x40000000 (2048.0) repeated 257 times → every o_rsp_ovr=1; o_ovr_cnt saturates at 255; i_ovr_clr together with a 258th overflow → o_ovr_cnt=0.
- i_rst_n pulsed low during MUL → all outputs 0 immediately; no o_rsp_valid afterwards; next grant goes to the lowest-index valid requester (pointer=0).
